mips_mc_control: RTL and testbench

Main control unit for the multicycle MIPS core: a Moore state machine that sequences the shared datapath (PC, IR, register file, ALU, ALUOut) and the single-port unified instruction/data memory. It walks through fetch, decode, execute, memory and writeback one state per clock. It drives every datapath enable and mux select from the current opcode, funct field and ALU zero flag. It sits inside `mips_core` between the instruction register and the datapath. Memory reads are registered: data appears on `read_data` one cycle after the address.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_alu_decoder.sv | 31 +++
 rtl/mips_mc_control.sv | 166 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, funct codes,
// ALU control codes, datapath select encodings and the control FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_IRLOAD  = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: is_supported = 1'b1;
            default:                                               is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's alu_op request plus the R-type
// funct field onto the 3-bit ALU function code.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes fall back to add
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: a Moore FSM sequencing fetch, decode, execute,
// memory and writeback, driving every datapath enable and mux select.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t  cur_state;
    state_t  next_state;
    alu_op_t alu_op;

    logic pc_write;
    logic branch;
    logic is_bne;
    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;
    logic instr_done_raw;
    logic illegal_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:  next_state = S_IRLOAD;
            S_IRLOAD: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    next_state = S_MEMADR;
                    OP_RTYPE:        next_state = S_EXECUTE;
                    OP_BEQ, OP_BNE:  next_state = S_BRANCH;
                    OP_ADDI:         next_state = S_ADDIEX;
                    OP_J:            next_state = S_JUMP;
                    default:         next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write       = 1'b0;
        branch         = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        mem_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        illegal_raw    = 1'b0;
        iord           = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_REG;
        pc_src         = PCSRC_ALU;
        alu_op         = ALUOP_ADD;
        case (cur_state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_IRLOAD: begin
                ir_write_raw = 1'b1;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b   = SRCB_IMM_SH;
                illegal_raw = !is_supported(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg     = 1'b1;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWR: begin
                iord           = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst        = 1'b1;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a      = 1'b1;
                alu_op         = ALUOP_SUB;
                pc_src         = PCSRC_ALUOUT;
                branch         = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src         = PCSRC_JUMP;
                pc_write       = 1'b1;
                instr_done_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // Reset gates the enables combinationally so an interrupted instruction never writes
    assign is_bne     = (opcode == OP_BNE);
    assign pc_en      = !rst && (pc_write || (branch && (zero ^ is_bne)));
    assign ir_write   = !rst && ir_write_raw;
    assign reg_write  = !rst && reg_write_raw;
    assign mem_write  = !rst && mem_write_raw;
    assign instr_done = !rst && instr_done_raw;
    assign illegal_op = !rst && illegal_raw;
    assign state      = cur_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control: walks each instruction class
// cycle by cycle and compares state and control outputs to hand-derived values.
module tb_mips_mc_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_mc_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .iord        (iord),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd12};
        rst = 1'b1; opcode = 6'h02; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++; $display("[TB] FAIL reset_state cyc=%0d got %0d exp 0", i, state);
            end
            checks++;
            if ({pc_en, ir_write, reg_write, mem_write, instr_done, illegal_op} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL reset_enables cyc=%0d got %b exp 000000", i,
                         {pc_en, ir_write, reg_write, mem_write, instr_done, illegal_op});
            end
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            checks++;
            if (state !== seq[c]) begin
                errors++; $display("[TB] FAIL reset_seq c=%0d got %0d exp %0d", c, state, seq[c]);
            end
            if (c == 0) begin
                checks++;
                if ({pc_en, iord, alu_src_b, alu_control} !== {1'b1, 1'b0, 2'b01, 3'b010}) begin
                    errors++;
                    $display("[TB] FAIL fetch_outputs got pc_en=%b iord=%b srcb=%b alu=%b exp 1 0 01 010",
                             pc_en, iord, alu_src_b, alu_control);
                end
            end
            if (c == 1) begin
                checks++;
                if ({ir_write, pc_en} !== 2'b10) begin
                    errors++; $display("[TB] FAIL irload got ir_write=%b pc_en=%b exp 1 0", ir_write, pc_en);
                end
            end
            if (c == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, illegal_op} !== {1'b0, 2'b11, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL decode got srca=%b srcb=%b illegal=%b exp 0 11 0",
                             alu_src_a, alu_src_b, illegal_op);
                end
            end
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_return got %0d exp 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8};
        for (int v = 0; v < 6; v++) begin
            opcode = 6'h00; funct = fn[v];
            #1;
            for (int c = 0; c < 5; c++) begin
                if (c > 0) tick();
                checks++;
                if (state !== seq[c]) begin
                    errors++; $display("[TB] FAIL rtype_state v=%0d c=%0d got %0d exp %0d", v, c, state, seq[c]);
                end
                checks++;
                if (instr_done !== 1'(c == 4)) begin
                    errors++; $display("[TB] FAIL rtype_done v=%0d c=%0d got %b", v, c, instr_done);
                end
                if (c == 3) begin
                    checks++;
                    if ({alu_control, alu_src_a, alu_src_b} !== {ac[v], 1'b1, 2'b00}) begin
                        errors++;
                        $display("[TB] FAIL rtype_exec v=%0d got alu=%b srca=%b srcb=%b exp %b 1 00",
                                 v, alu_control, alu_src_a, alu_src_b, ac[v]);
                    end
                end
                if (c == 4) begin
                    checks++;
                    if ({reg_write, reg_dst, mem_to_reg, mem_write} !== 4'b1100) begin
                        errors++;
                        $display("[TB] FAIL rtype_wb v=%0d got rw=%b rd=%b m2r=%b mw=%b exp 1 1 0 0",
                                 v, reg_write, reg_dst, mem_to_reg, mem_write);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0] lw_seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [3:0] sw_seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
        int mw_count;
        opcode = 6'h23; funct = 6'h00;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            checks++;
            if (state !== lw_seq[c]) begin
                errors++; $display("[TB] FAIL lw_state c=%0d got %0d exp %0d", c, state, lw_seq[c]);
            end
            checks++;
            if (mem_write !== 1'b0) begin
                errors++; $display("[TB] FAIL lw_memwrite c=%0d got %b exp 0", c, mem_write);
            end
            if (c == 3) begin
                checks++;
                if ({alu_src_a, alu_src_b, iord} !== {1'b1, 2'b10, 1'b0}) begin
                    errors++; $display("[TB] FAIL lw_memadr got srca=%b srcb=%b iord=%b exp 1 10 0",
                                       alu_src_a, alu_src_b, iord);
                end
            end
            if (c == 4) begin
                checks++;
                if ({iord, reg_write} !== 2'b10) begin
                    errors++; $display("[TB] FAIL lw_memrd got iord=%b rw=%b exp 1 0", iord, reg_write);
                end
            end
            if (c == 5) begin
                checks++;
                if ({mem_to_reg, reg_write, reg_dst, instr_done} !== 4'b1101) begin
                    errors++;
                    $display("[TB] FAIL lw_memwb got m2r=%b rw=%b rd=%b done=%b exp 1 1 0 1",
                             mem_to_reg, reg_write, reg_dst, instr_done);
                end
            end
        end
        tick();
        opcode = 6'h2B;
        #1;
        mw_count = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (mem_write === 1'b1) mw_count++;
            checks++;
            if (state !== sw_seq[c]) begin
                errors++; $display("[TB] FAIL sw_state c=%0d got %0d exp %0d", c, state, sw_seq[c]);
            end
            if (c == 4) begin
                checks++;
                if ({iord, mem_write, instr_done, reg_write} !== 4'b1110) begin
                    errors++;
                    $display("[TB] FAIL sw_memwr got iord=%b mw=%b done=%b rw=%b exp 1 1 1 0",
                             iord, mem_write, instr_done, reg_write);
                end
            end
        end
        tick();
        if (mem_write === 1'b1) mw_count++;
        checks++;
        if (mw_count != 1) begin
            errors++; $display("[TB] FAIL sw_memwrite_count got %0d exp 1", mw_count);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
        logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd9};
        for (int v = 0; v < 4; v++) begin
            opcode = ops[v]; zero = zs[v];
            #1;
            for (int c = 0; c < 4; c++) begin
                if (c > 0) tick();
                checks++;
                if (state !== seq[c]) begin
                    errors++; $display("[TB] FAIL br_state v=%0d c=%0d got %0d exp %0d", v, c, state, seq[c]);
                end
                if (c == 3) begin
                    checks++;
                    if (pc_en !== exp[v]) begin
                        errors++; $display("[TB] FAIL br_pc_en v=%0d got %b exp %b", v, pc_en, exp[v]);
                    end
                    checks++;
                    if ({pc_src, alu_control, alu_src_a, instr_done} !== {2'b01, 3'b110, 1'b1, 1'b1}) begin
                        errors++;
                        $display("[TB] FAIL br_outputs v=%0d got pcsrc=%b alu=%b srca=%b done=%b exp 01 110 1 1",
                                 v, pc_src, alu_control, alu_src_a, instr_done);
                    end
                end
            end
            tick();
            zero = 1'b0;
        end
    endtask

    task automatic test_illegal_jump();
        logic [3:0] j_seq [4] = '{4'd0, 4'd1, 4'd2, 4'd12};
        opcode = 6'h3F;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            checks++;
            if (illegal_op !== 1'(c == 2)) begin
                errors++; $display("[TB] FAIL illegal_pulse c=%0d got %b", c, illegal_op);
            end
        end
        tick();
        checks++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL illegal_return got state=%0d illegal=%b exp 0 0", state, illegal_op);
        end
        opcode = 6'h02;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            checks++;
            if (state !== j_seq[c]) begin
                errors++; $display("[TB] FAIL jump_state c=%0d got %0d exp %0d", c, state, j_seq[c]);
            end
        end
        checks++;
        if ({pc_src, pc_en, instr_done} !== {2'b10, 1'b1, 1'b1}) begin
            errors++; $display("[TB] FAIL jump_outputs got pcsrc=%b pc_en=%b done=%b exp 10 1 1",
                               pc_src, pc_en, instr_done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] addi_seq [5] = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd11};
        opcode = 6'h23;
        #1;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (state !== 4'd5) begin
            errors++; $display("[TB] FAIL rstmid_reach got %0d exp 5", state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({reg_write, instr_done, mem_write} !== 3'b000) begin
            errors++; $display("[TB] FAIL rstmid_memwb got rw=%b done=%b mw=%b exp 0 0 0",
                               reg_write, instr_done, mem_write);
        end
        tick();
        checks++;
        if ({state, pc_en, reg_write, mem_write} !== {4'd0, 3'b000}) begin
            errors++; $display("[TB] FAIL rstmid_after got state=%0d pc_en=%b rw=%b mw=%b exp 0 0 0 0",
                               state, pc_en, reg_write, mem_write);
        end
        rst = 1'b0; opcode = 6'h08;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++;
            if (state !== addi_seq[c]) begin
                errors++; $display("[TB] FAIL addi_state c=%0d got %0d exp %0d", c, state, addi_seq[c]);
            end
            checks++;
            if ({reg_write, mem_write} !== {1'(c == 4), 1'b0}) begin
                errors++; $display("[TB] FAIL addi_writes c=%0d got rw=%b mw=%b", c, reg_write, mem_write);
            end
            if (c == 3) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_control} !== {1'b1, 2'b10, 3'b010}) begin
                    errors++; $display("[TB] FAIL addi_exec got srca=%b srcb=%b alu=%b exp 1 10 010",
                                       alu_src_a, alu_src_b, alu_control);
                end
            end
            if (c == 4) begin
                checks++;
                if ({reg_dst, mem_to_reg, instr_done} !== 3'b001) begin
                    errors++; $display("[TB] FAIL addi_wb got rd=%b m2r=%b done=%b exp 0 0 1",
                                       reg_dst, mem_to_reg, instr_done);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch();
        test_illegal_jump();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
